// File: rtl/cpu_datapath.sv
// Single-cycle CPU datapath: nine-entry register file (R0-R7 plus temp R8),
// function unit with Z/N/C/V flag generation, and data-memory interface.
module cpu_datapath #(
  parameter int bw = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [12:0]   cw,
  input  logic [2:0]    DA,
  input  logic [2:0]    AA,
  input  logic [2:0]    BA,
  input  logic [bw-1:0] mem_rdata,
  output logic [3:0]    psw,
  output logic [bw-1:0] mem_addr,
  output logic [bw-1:0] mem_wdata,
  output logic          mem_we
);

  logic [3:0] fs;
  logic       mb, md, rw, mw, psl, td, ta, tb;
  logic       unused_cw0;

  assign fs         = cw[12:9];
  assign mb         = cw[8];
  assign md         = cw[7];
  assign rw         = cw[6];
  assign mw         = cw[5];
  assign psl        = cw[4];
  assign td         = cw[3];
  assign ta         = cw[2];
  assign tb         = cw[1];
  assign unused_cw0 = cw[0];

  logic [bw-1:0] regs [0:7];
  logic [bw-1:0] r8;
  logic [bw-1:0] bus_a, bus_b, bus_d, b_src;

  assign bus_a = ta ? r8 : regs[AA];
  assign b_src = tb ? r8 : regs[BA];
  assign bus_b = mb ? {{(bw-3){1'b0}}, BA} : b_src;

  // Adder operand/carry selection shared by all arithmetic codes
  logic [bw-1:0] op2;
  logic          cin;
  logic [bw:0]   sum;

  always_comb begin
    op2 = '0;
    cin = 1'b0;
    case (fs)
      4'b0001: cin = 1'b1;
      4'b0010: op2 = bus_b;
      4'b0011: begin op2 = bus_b;  cin = 1'b1; end
      4'b0100: op2 = ~bus_b;
      4'b0101: begin op2 = ~bus_b; cin = 1'b1; end
      4'b0110: op2 = '1;
      default: ;
    endcase
    sum = {1'b0, bus_a} + {1'b0, op2} + {{bw{1'b0}}, cin};
  end

  logic [bw-1:0] f;
  logic          z, n, c, v;

  always_comb begin
    f = bus_a;
    c = 1'b0;
    v = 1'b0;
    case (fs)
      4'b0001, 4'b0010, 4'b0011, 4'b0100, 4'b0101, 4'b0110: begin
        f = sum[bw-1:0];
        c = sum[bw];
        v = (bus_a[bw-1] == op2[bw-1]) && (sum[bw-1] != bus_a[bw-1]);
      end
      4'b1000: f = bus_a & bus_b;
      4'b1001: f = bus_a | bus_b;
      4'b1010: f = bus_a ^ bus_b;
      4'b1011: f = ~bus_a;
      4'b1100: f = bus_b;
      4'b1101: begin f = {1'b0, bus_b[bw-1:1]};         c = bus_b[0];    end
      4'b1110: begin f = {bus_b[bw-2:0], 1'b0};         c = bus_b[bw-1]; end
      4'b1111: begin f = {bus_b[bw-1], bus_b[bw-1:1]};  c = bus_b[0];    end
      default: f = bus_a;
    endcase
  end

  assign z     = (f == '0);
  assign n     = f[bw-1];
  assign bus_d = md ? mem_rdata : f;

  // Writes use pre-edge operands, so DA==AA gives a one-cycle read-modify-write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) regs[i] <= '0;
      r8 <= '0;
    end else if (rw) begin
      if (td) r8 <= bus_d;
      else    regs[DA] <= bus_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)      psw <= 4'b0000;
    else if (psl) psw <= {z, n, c, v};
  end

  assign mem_addr  = bus_a;
  assign mem_wdata = bus_b;
  assign mem_we    = mw;

endmodule

// File: tb/tb_cpu_datapath.sv
// Directed self-checking bench for cpu_datapath; registers are observed via
// bus A on mem_addr, and every expected value is hand-computed.
module tb_cpu_datapath;

  logic        clk;
  logic        rst;
  logic [12:0] cw;
  logic [2:0]  DA, AA, BA;
  logic [15:0] mem_rdata;
  logic [3:0]  psw;
  logic [15:0] mem_addr, mem_wdata;
  logic        mem_we;

  int n_checks = 0;
  int n_errors = 0;

  localparam logic [7:0] F_MB  = 8'h80;
  localparam logic [7:0] F_MD  = 8'h40;
  localparam logic [7:0] F_RW  = 8'h20;
  localparam logic [7:0] F_MW  = 8'h10;
  localparam logic [7:0] F_PSL = 8'h08;
  localparam logic [7:0] F_TD  = 8'h04;
  localparam logic [7:0] F_TA  = 8'h02;
  localparam logic [7:0] F_TB  = 8'h01;

  cpu_datapath #(.bw(16)) dut (
    .clk(clk), .rst(rst), .cw(cw), .DA(DA), .AA(AA), .BA(BA),
    .mem_rdata(mem_rdata), .psw(psw), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  function automatic logic [12:0] mk_cw(input logic [3:0] fs, input logic [7:0] flags);
    return {fs, flags, 1'b0};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_reg(input int idx, output logic [15:0] val);
    if (idx == 8) cw = mk_cw(4'b0000, F_TA);
    else begin
      cw = mk_cw(4'b0000, 8'h00);
      AA = idx[2:0];
    end
    #1;
    val = mem_addr;
  endtask

  task automatic load_reg(input int idx, input logic [15:0] val);
    mem_rdata = val;
    if (idx == 8) cw = mk_cw(4'b0000, F_MD | F_RW | F_TD);
    else begin
      cw = mk_cw(4'b0000, F_MD | F_RW);
      DA = idx[2:0];
    end
    tick();
    cw = '0;
  endtask

  task automatic test_reset();
    logic [15:0] val;
    rst = 1'b1;
    cw = mk_cw(4'b1100, F_MW);
    DA = 0; AA = 0; BA = 0; mem_rdata = '0;
    #3;
    n_checks++;
    if (mem_we !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL reset_mem_we: got %b expected 1", mem_we);
    end
    for (int i = 0; i < 9; i++) begin
      read_reg(i, val);
      n_checks++;
      if (val !== 16'h0000) begin
        n_errors++;
        $display("[TB] FAIL reset_reg%0d: got %h expected 0000", i, val);
      end
    end
    n_checks++;
    if (psw !== 4'b0000) begin
      n_errors++;
      $display("[TB] FAIL reset_psw: got %b expected 0000", psw);
    end
    tick();
    rst = 1'b0;
    tick();
    // pending write to R5 overridden by a reset pulse across the edge
    cw = mk_cw(4'b1100, F_MB | F_RW); DA = 5; BA = 5;
    #2 rst = 1'b1;
    @(posedge clk);
    #1;
    cw = '0;
    rst = 1'b0;
    read_reg(5, val);
    n_checks++;
    if (val !== 16'h0000) begin
      n_errors++;
      $display("[TB] FAIL reset_mid_write: got %h expected 0000", val);
    end
    cw = mk_cw(4'b1100, F_MB | F_RW); DA = 5; BA = 5;
    tick();
    read_reg(5, val);
    n_checks++;
    if (val !== 16'h0005) begin
      n_errors++;
      $display("[TB] FAIL first_edge_write: got %h expected 0005", val);
    end
  endtask

  task automatic test_add();
    logic [15:0] val;
    cw = mk_cw(4'b1100, F_MB | F_RW); BA = 5; DA = 1; tick();
    cw = mk_cw(4'b1100, F_MB | F_RW); BA = 7; DA = 2; tick();
    cw = mk_cw(4'b0010, F_RW | F_PSL); AA = 1; BA = 2; DA = 3; tick();
    read_reg(3, val);
    n_checks++;
    if (val !== 16'd12) begin
      n_errors++;
      $display("[TB] FAIL add_r3: got %h expected 000c", val);
    end
    n_checks++;
    if (psw !== 4'b0000) begin
      n_errors++;
      $display("[TB] FAIL add_psw: got %b expected 0000", psw);
    end
  endtask

  task automatic test_overflow();
    logic [15:0] val;
    load_reg(1, 16'h7FFF);
    cw = mk_cw(4'b0001, F_RW | F_PSL); AA = 1; DA = 1; tick();
    read_reg(1, val);
    n_checks++;
    if (val !== 16'h8000) begin
      n_errors++;
      $display("[TB] FAIL inc_r1: got %h expected 8000", val);
    end
    n_checks++;
    if (psw !== 4'b0101) begin
      n_errors++;
      $display("[TB] FAIL inc_psw: got %b expected 0101", psw);
    end
    cw = mk_cw(4'b0101, F_RW | F_PSL | F_TD); AA = 1; BA = 1; tick();
    read_reg(8, val);
    n_checks++;
    if (val !== 16'h0000) begin
      n_errors++;
      $display("[TB] FAIL sub_r8: got %h expected 0000", val);
    end
    n_checks++;
    if (psw !== 4'b1010) begin
      n_errors++;
      $display("[TB] FAIL sub_psw: got %b expected 1010", psw);
    end
  endtask

  // Each row: fs, A value (R1), B value (R2), expected F, expected psw
  task automatic test_alu_table();
    logic [3:0]  fs_t  [10] = '{4'b1000, 4'b1001, 4'b1010, 4'b1011, 4'b0110,
                               4'b0101, 4'b0111, 4'b0011, 4'b0100, 4'b0000};
    logic [15:0] f_t   [10] = '{16'h00F0, 16'hFFF0, 16'hFF00, 16'h0F0F, 16'hF0EF,
                               16'hE100, 16'hF0F0, 16'h00E1, 16'hE0FF, 16'hF0F0};
    logic [3:0]  psw_t [10] = '{4'b0000, 4'b0100, 4'b0100, 4'b0000, 4'b0110,
                               4'b0110, 4'b0100, 4'b0010, 4'b0110, 4'b0100};
    logic [15:0] val;
    load_reg(1, 16'hF0F0);
    load_reg(2, 16'h0FF0);
    for (int i = 0; i < 10; i++) begin
      cw = mk_cw(fs_t[i], F_RW | F_PSL | F_TD); AA = 1; BA = 2; tick();
      read_reg(8, val);
      n_checks++;
      if (val !== f_t[i]) begin
        n_errors++;
        $display("[TB] FAIL alu_f fs=%b: got %h expected %h", fs_t[i], val, f_t[i]);
      end
      n_checks++;
      if (psw !== psw_t[i]) begin
        n_errors++;
        $display("[TB] FAIL alu_psw fs=%b: got %b expected %b", fs_t[i], psw, psw_t[i]);
      end
    end
  endtask

  task automatic test_shift();
    logic [3:0]  fs_t  [3] = '{4'b1110, 4'b1111, 4'b1101};
    logic [15:0] f_t   [3] = '{16'h0002, 16'hC000, 16'h4000};
    logic [3:0]  psw_t [3] = '{4'b0010, 4'b0110, 4'b0010};
    logic [15:0] val;
    load_reg(4, 16'h8001);
    for (int i = 0; i < 3; i++) begin
      cw = mk_cw(fs_t[i], F_RW | F_PSL | F_TD); BA = 4; tick();
      read_reg(8, val);
      n_checks++;
      if (val !== f_t[i]) begin
        n_errors++;
        $display("[TB] FAIL shift_f fs=%b: got %h expected %h", fs_t[i], val, f_t[i]);
      end
      n_checks++;
      if (psw !== psw_t[i]) begin
        n_errors++;
        $display("[TB] FAIL shift_psw fs=%b: got %b expected %b", fs_t[i], psw, psw_t[i]);
      end
    end
  endtask

  task automatic test_memory();
    logic [15:0] val;
    load_reg(0, 16'h0040);
    load_reg(7, 16'h1234);
    cw = mk_cw(4'b0000, 8'h00); AA = 0; BA = 7;
    #1;
    n_checks++;
    if (mem_we !== 1'b0) begin
      n_errors++;
      $display("[TB] FAIL mem_we_idle: got %b expected 0", mem_we);
    end
    cw = mk_cw(4'b0000, F_MW);
    #1;
    n_checks++;
    if (mem_addr !== 16'h0040 || mem_wdata !== 16'h1234 || mem_we !== 1'b1) begin
      n_errors++;
      $display("[TB] FAIL mem_store: got addr=%h wdata=%h we=%b expected 0040 1234 1",
               mem_addr, mem_wdata, mem_we);
    end
    tick();
    mem_rdata = 16'hBEEF;
    cw = mk_cw(4'b0000, F_MD | F_RW | F_TD); DA = 7; tick();
    read_reg(8, val);
    n_checks++;
    if (val !== 16'hBEEF) begin
      n_errors++;
      $display("[TB] FAIL mem_load_r8: got %h expected beef", val);
    end
    read_reg(7, val);
    n_checks++;
    if (val !== 16'h1234) begin
      n_errors++;
      $display("[TB] FAIL mem_load_r7: got %h expected 1234", val);
    end
    n_checks++;
    if (psw !== 4'b0010) begin
      n_errors++;
      $display("[TB] FAIL psw_hold: got %b expected 0010", psw);
    end
  endtask

  task automatic test_back_to_back();
    load_reg(6, 16'd3);
    cw = mk_cw(4'b0010, F_RW); DA = 6; AA = 6; BA = 6;
    tick();
    n_checks++;
    if (mem_addr !== 16'd6) begin
      n_errors++;
      $display("[TB] FAIL rmw_first: got %h expected 0006", mem_addr);
    end
    tick();
    n_checks++;
    if (mem_addr !== 16'd12) begin
      n_errors++;
      $display("[TB] FAIL rmw_second: got %h expected 000c", mem_addr);
    end
    cw = '0;
  endtask

  initial begin
    test_reset();
    test_add();
    test_overflow();
    test_alu_table();
    test_shift();
    test_memory();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/cpu_datapath.md
CPU_DATAPATH -- requirements
Module: cpu_datapath

Interface
REQ-001 SHALL have parameter bw, default 16, giving the datapath word width; all data values below assume bw=16.
REQ-002 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 SHALL have port cw, input, 13, control word from cpu_cont.
REQ-005 SHALL have ports DA, AA, BA, input, 3 each: destination, A-source and B-source register addresses from cpu_cont.
REQ-006 SHALL have port mem_rdata, input, bw, data memory read data.
REQ-007 SHALL have port psw, output, 4, flag register {Z,N,C,V} in bits [3:0] (Z=bit3, N=bit2, C=bit1, V=bit0), fed back to cpu_cont.
REQ-008 SHALL have ports mem_addr (output, bw), mem_wdata (output, bw) and mem_we (output, 1) for the data memory.

Function
REQ-009 SHALL decode cw as: [12:9] FS, [8] MB, [7] MD, [6] RW, [5] MW, [4] PSL, [3] TD, [2] TA, [1] TB; cw[0] is reserved and SHALL be ignored.
REQ-010 SHALL hold a register file of nine bw-bit registers: R0-R7 plus temporary register R8, all writable.
REQ-011 Effective addresses: dest = TD ? R8 : R[DA]; A-source = TA ? R8 : R[AA]; B-source = TB ? R8 : R[BA].
REQ-012 Register reads SHALL be combinational; bus A = A-source value; bus B = MB ? {13'b0, BA} : B-source value.
REQ-013 Function unit SHALL compute F from FS, combinationally:
- 0000 A; 0001 A+1; 0010 A+B; 0011 A+B+1
- 0100 A+~B; 0101 A+~B+1; 0110 A+16'hFFFF; 0111 A
- 1000 A&B; 1001 A|B; 1010 A^B; 1011 ~A
- 1100 B; 1101 B>>1 (logical); 1110 B<<1; 1111 B>>>1 (arithmetic)
REQ-014 Arithmetic codes (0001-0110) SHALL use a 17-bit sum: C = bit 16; V = 1 iff both operands as added have the same sign and the result sign differs.
REQ-015 Shift codes: C = bit shifted out (B[0] for 1101/1111, B[15] for 1110); V = 0.
REQ-016 Codes 0000, 0111 and 1000-1100: C = 0, V = 0.
REQ-017 For all codes: Z = (F == 0); N = F[15].
REQ-018 Bus D SHALL be MD ? mem_rdata : F.
REQ-019 When RW=1, the dest register SHALL load bus D on the rising clock edge.
REQ-020 A same-cycle read of the register being written SHALL return the old value; no bypass.
REQ-021 When PSL=1, psw SHALL load {Z,N,C,V} on the rising edge, computed from F regardless of MD; when PSL=0, psw SHALL hold.
REQ-022 mem_addr SHALL equal bus A, mem_wdata SHALL equal bus B, and mem_we SHALL equal MW, all combinationally; the memory samples them on the next rising edge.
REQ-023 RW and PSL in the same cycle SHALL both take effect on the same edge, using the pre-edge operand values.
REQ-024 When DA==AA with RW=1, the write SHALL use F computed from the old value (read-modify-write in one cycle).
REQ-025 Arithmetic SHALL wrap modulo 2^16 with no saturation.

Reset
REQ-026 While rst=1: R0-R8 = 0 and psw = 4'b0000, immediately and independent of clk.
REQ-027 Reset asserted mid-operation SHALL override any pending RW or PSL write on that edge.
REQ-028 Combinational outputs SHALL follow cw and register contents during reset; mem_we = MW.
REQ-029 After rst deasserts, the first rising edge SHALL perform normal writes.

Verification
REQ-030 Reset, then read all registers via FS=0000 -> F=0, psw=0000; pulse rst mid-write with RW=1 -> target stays 0.
REQ-031 MB=1, BA=5, FS=1100, RW=1, DA=1; then FS=1100, MB=1, BA=7, DA=2; then FS=0010, AA=1, BA=2, DA=3, PSL=1 -> R3=12, psw=0000.
REQ-032 R1=16'h7FFF, FS=0001, DA=1, PSL=1 -> R1=16'h8000, psw=0101 (N=1, V=1); then FS=0101 with R1 and B=R1 -> F=0, psw=1010 (Z=1, C=1).
REQ-033 R4=16'h8001: FS=1110 -> F=16'h0002, C=1; FS=1111 -> F=16'hC000, C=1; FS=1101 -> F=16'h4000, C=1.
REQ-034 MW=1, AA->16'h0040, BA->16'h1234 -> mem_addr=0040, mem_wdata=1234, mem_we=1; then MD=1, mem_rdata=16'hBEEF, RW=1, TD=1 -> R8=BEEF, R[DA] unchanged.
REQ-035 RW=1 with DA=AA=BA=6 and R6=3, FS=0010 -> R6=6 after one edge, 12 after the next.
